// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch controller: address windows,
// controller states, buffer entry layout and the fetch-address legality check.
package imem_pkg;

    localparam logic [31:0] BOOT_BASE    = 32'h9fc0_0000;
    localparam logic [31:0] USER_BASE    = 32'h0040_0000;
    localparam logic [31:0] WINDOW_BYTES = 32'h0000_0400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } buf_entry_t;

    // A fetch address is legal when word-aligned and inside one of the two windows.
    function automatic logic pc_is_legal(input logic [31:0] pc);
        logic in_boot;
        logic in_user;
        in_boot = (pc >= BOOT_BASE) && (pc < (BOOT_BASE + WINDOW_BYTES));
        in_user = (pc >= USER_BASE) && (pc < (USER_BASE + WINDOW_BYTES));
        return (pc[1:0] == 2'b00) && (in_boot || in_user);
    endfunction

endpackage

// File: rtl/imem_fetch_buf.sv
// Two-entry FIFO holding fetched instructions (or fault markers) for decode.
// The head entry is held in registers, so it stays stable while stalled.
module imem_fetch_buf
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  buf_entry_t wr_entry,
    input  logic       pop,
    output buf_entry_t head,
    output logic [1:0] count
);

    buf_entry_t mem_r [2];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;
    logic       pop_ok_s;
    logic       push_ok_s;

    // Qualify pop with non-empty and push with room (a pop frees room when full).
    always_comb begin
        pop_ok_s  = pop && (count_r != 2'd0);
        push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    end

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_entry;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: issues reads to a 256-word synchronous
// instruction memory, buffers returned words in a 2-entry FIFO and presents
// them to decode with a valid/ready handshake. Illegal fetch addresses produce
// a single fault entry and halt fetching until a redirect.
// Optional build macro IMEM_FETCH_TRACE_EN adds a simulation-only transfer trace.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h9fc0_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        inst_addr_err
);

    localparam logic [2:0] BUF_MAX = 3'(BUF_DEPTH);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  inflight_pc_r, inflight_pc_nxt_s;
    logic         inflight_r, inflight_nxt_s;
    logic         issue_s;
    logic         push_s;
    logic         pop_s;
    logic         flush_s;
    logic         pc_legal_s;
    buf_entry_t   push_entry_s;
    buf_entry_t   head_s;
    logic [1:0]   count_s;
    logic [2:0]   occ_s;
    logic [2:0]   room_s;

    assign pc_legal_s = pc_is_legal(pc_r);
    assign pop_s      = inst_valid && inst_ready;
    // Committed slots (buffered + in flight) once this cycle's pop is accounted for.
    assign occ_s      = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign room_s     = {1'b0, count_s} - {2'b00, pop_s};

    // Next-state, read issue and buffer-write decisions; redirect overrides all.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        inflight_nxt_s    = 1'b0;
        inflight_pc_nxt_s = inflight_pc_r;
        issue_s           = 1'b0;
        push_s            = 1'b0;
        push_entry_s      = '0;
        flush_s           = 1'b0;
        if (redirect_valid) begin
            flush_s     = 1'b1;
            pc_nxt_s    = redirect_pc;
            state_nxt_s = ST_RUN;
        end else begin
            if (inflight_r) begin
                push_s       = 1'b1;
                push_entry_s = '{pc: inflight_pc_r, data: imem_rdata, err: 1'b0};
            end else begin
                push_s = 1'b0;
            end
            case (state_r)
                ST_IDLE: state_nxt_s = ST_RUN;
                ST_RUN: begin
                    if (pc_legal_s && (occ_s < BUF_MAX)) begin
                        issue_s           = 1'b1;
                        pc_nxt_s          = pc_r + 32'd4;
                        inflight_nxt_s    = 1'b1;
                        inflight_pc_nxt_s = pc_r;
                    end else if (!pc_legal_s && !inflight_r && (room_s < BUF_MAX)) begin
                        // Fault waits for any in-flight word so ordering is kept.
                        push_s       = 1'b1;
                        push_entry_s = '{pc: pc_r, data: 32'h0000_0000, err: 1'b1};
                        state_nxt_s  = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Controller state, fetch pc and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            inflight_r    <= inflight_nxt_s;
            inflight_pc_r <= inflight_pc_nxt_s;
        end
    end

    imem_fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_s),
        .push     (push_s),
        .wr_entry (push_entry_s),
        .pop      (pop_s),
        .head     (head_s),
        .count    (count_s)
    );

    assign imem_en       = issue_s;
    assign imem_addr     = pc_r[9:2];
    assign inst_valid    = (count_s != 2'd0);
    assign inst_pc       = head_s.pc;
    assign inst_data     = head_s.data;
    assign inst_addr_err = head_s.err;

`ifdef IMEM_FETCH_TRACE_EN
    // Simulation-only trace of every transfer accepted by decode.
    always @(posedge clk) begin
        if (rst_n && pop_s) begin
            if (head_s.err) begin
                $display("[%h] Invalid Address", head_s.pc);
            end else begin
                $display("[%h] %h", head_s.pc, head_s.data);
            end
        end
    end
`else
    // Default build carries no trace hooks.
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl. The reference model is the expected instruction
// stream: from the current start pc, consecutive words while the pc is legal,
// then one fault entry, then nothing until the next redirect or reset.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_addr_err;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_addr_err  (inst_addr_err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after imem_en.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    bit          halted;
    int          issued;
    int          delivered;
    int          acc_since;
    logic [31:0] first_pc;
    logic [31:0] last_pc;
    logic        last_err;
    bit          prev_stall;
    logic [64:0] prev_head;

    function automatic bit ref_legal(input logic [31:0] a);
        return ((a % 4) == 0) &&
               (((a >= 32'h9fc0_0000) && (a <= 32'h9fc0_03fc)) ||
                ((a >= 32'h0040_0000) && (a <= 32'h0040_03fc)));
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_pc     = pc;
        halted     = 1'b0;
        issued     = 0;
        delivered  = 0;
        acc_since  = 0;
        prev_stall = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, sample 1 unit later.
    task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [64:0] head;
        logic [64:0] exp_e;
        @(negedge clk);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        head = {inst_pc, inst_data, inst_addr_err};
        if (prev_stall) begin
            check("stall_valid", inst_valid, 1'b1);
            check("stall_stable", head, prev_head);
        end
        if (rv) check("redirect_no_read", imem_en, 1'b0);
        if (halted && !rv) begin
            check("halt_no_read", imem_en, 1'b0);
            check("halt_no_valid", inst_valid, 1'b0);
        end
        if (inst_valid && rdy && !halted) begin
            if (ref_legal(exp_pc)) exp_e = {exp_pc, mem[exp_pc[9:2]], 1'b0};
            else                   exp_e = {exp_pc, 32'h0, 1'b1};
            check("deliver", head, exp_e);
            if (acc_since == 0) first_pc = inst_pc;
            acc_since++;
            last_pc  = inst_pc;
            last_err = inst_addr_err;
            if (exp_e[0]) halted = 1'b1;
            else begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        if (imem_en) issued++;
        check("occupancy_le2", ((issued - delivered) <= 2), 1'b1);
        prev_stall = inst_valid && !rdy && !rv;
        prev_head  = head;
        if (rv) model_restart(rpc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int          first_valid;
    int          acc_before;
    logic [31:0] tgt;
    bit          rv;

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? 32'(i) : $urandom();
        model_restart(32'h9fc0_0000);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_imem_en", imem_en, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_err", inst_addr_err, 1'b0);

        // Release: IDLE cycle issues nothing; cycle k = interval after k-th edge from release
        @(negedge clk);
        rst_n = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("idle_no_read", imem_en, 1'b0);
        first_valid = -1;
        for (int t = 0; t < 12; t++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (inst_valid && (first_valid < 0)) first_valid = t;
        end
        check("first_valid_cycle", first_valid, 2);
        check("stream_count", acc_since, 10);
        check("stream_first_pc", first_pc, 32'h9fc0_0000);

        // Decode stall for 5 cycles, then resume at full rate
        repeat (5) tick(1'b0, 1'b0, 32'h0);
        check("stall_fill", issued - delivered, 2);
        acc_before = acc_since;
        repeat (6) tick(1'b1, 1'b0, 32'h0);
        check("resume_count", acc_since - acc_before, 6);

        // Redirect while buffer full
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        check("full_before_redirect", issued - delivered, 2);
        tick(1'b0, 1'b1, 32'h0040_0010);
        tick(1'b1, 1'b0, 32'h0);
        check("flush_empty", inst_valid, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 32'h0);
        check("redirect_first_pc", first_pc, 32'h0040_0010);
        check("redirect_count", acc_since, 5);

        // Last legal word, then fault at window end, then halt
        tick(1'b1, 1'b1, 32'h0040_03fc);
        repeat (8) tick(1'b1, 1'b0, 32'h0);
        check("edge_count", acc_since, 2);
        check("edge_first_pc", first_pc, 32'h0040_03fc);
        check("edge_fault_pc", last_pc, 32'h0040_0400);
        check("edge_fault_err", last_err, 1'b1);
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        check("edge_reads", issued, 1);

        // Misaligned target: single fault, no read
        tick(1'b1, 1'b1, 32'h9fc0_0002);
        repeat (6) tick(1'b1, 1'b0, 32'h0);
        check("misalign_count", acc_since, 1);
        check("misalign_pc", last_pc, 32'h9fc0_0002);
        check("misalign_err", last_err, 1'b1);
        check("misalign_reads", issued, 0);

        // Randomized handshake and redirects against the stream model
        for (int k = 0; k < 400; k++) begin
            rv = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 4))
                0:       tgt = 32'h9fc0_0000 + 32'($urandom_range(0, 255)) * 32'd4;
                1:       tgt = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 32'd4;
                2:       tgt = 32'h0040_03f0 + 32'($urandom_range(0, 3)) * 32'd4;
                3:       tgt = 32'h9fc0_0000 + 32'($urandom_range(0, 1023));
                default: tgt = $urandom();
            endcase
            tick(($urandom_range(0, 3) != 0), rv, tgt);
        end

        // Reset mid-stream
        tick(1'b1, 1'b1, 32'h9fc0_0100);
        repeat (6) tick(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_imem_en", imem_en, 1'b0);
        check("midrst_valid", inst_valid, 1'b0);
        check("midrst_pc", inst_pc, 32'h0);
        check("midrst_data", inst_data, 32'h0);
        check("midrst_err", inst_addr_err, 1'b0);
        model_restart(32'h9fc0_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick(1'b1, 1'b0, 32'h0);
        check("postrst_first_pc", first_pc, 32'h9fc0_0000);
        check("postrst_count", acc_since, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h9fc0_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: output buffer entries, fixed at 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_en  output  1  memory read strobe; read data returns the next cycle.
REQ-006 imem_addr  output  8  word index into 256-word memory, equal to pc[9:2].
REQ-007 imem_rdata  input  32  read data, valid one cycle after imem_en.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 inst_valid  output  1  instruction available to decode.
REQ-011 inst_ready  input  1  decode accepts; transfer occurs when inst_valid && inst_ready.
REQ-012 inst_pc  output  32  address of the presented instruction.
REQ-013 inst_data  output  32  presented instruction word.
REQ-014 inst_addr_err  output  1  presented entry is an address fault; inst_data is 0.

Function
REQ-015 Legal PC: word-aligned and in [32'h9fc0_0000, 32'h9fc0_0400) or [32'h0040_0000, 32'h0040_0400).
REQ-016 States: IDLE (one cycle after reset, no fetch), RUN (fetching), HALT (fault delivered, no fetch).
REQ-017 IDLE -> RUN unconditionally; RUN -> HALT when a fault entry is written to the buffer; HALT -> RUN only on redirect_valid.
REQ-018 In RUN, imem_en asserts for a legal pc only when buffered entries + in-flight reads < 2, counting a same-cycle pop.
REQ-019 Each issued read increments pc by 4; the word is written into the buffer the following cycle with its pc.
REQ-020 An illegal pc in RUN issues no read; it enqueues {pc, 32'h0, err=1} when space allows, then stays at that pc.
REQ-021 Buffer is a 2-entry FIFO; head drives inst_*; push and pop in the same cycle are allowed when full.
REQ-022 inst_valid = buffer not empty; inst_pc, inst_data and inst_addr_err remain stable while inst_valid && !inst_ready.
REQ-023 redirect_valid has priority over all other events: buffer flushed and in-flight read discarded; pc <= redirect_pc; state <= RUN; no read issued that cycle.
REQ-024 A pop coinciding with redirect completes normally; data returning the cycle after redirect is dropped.
REQ-025 Sustained throughput with inst_ready held high is one instruction per cycle after a 2-cycle initial latency (IDLE cycle plus read cycle).
REQ-026 pc + 4 wraps modulo 2^32; a wrapped or out-of-window pc is a fault under REQ-020.

Reset
REQ-027 On rst_n low: state=IDLE, pc=RESET_PC, buffer empty, in-flight cleared, imem_en=0, inst_valid=0, inst_pc=0, inst_data=0, inst_addr_err=0.
REQ-028 Reset mid-operation discards buffered and in-flight data; first fetch after release is RESET_PC.

Configuration
REQ-029 Macro IMEM_FETCH_TRACE_EN: when defined, a simulation-only $display prints "[pc] data" for every accepted transfer and "[pc] Invalid Address" for every accepted fault.
REQ-030 Without IMEM_FETCH_TRACE_EN, no display statements are present and logic is identical.

Structure
REQ-031 Shared package imem_pkg holds the window constants (BOOT_BASE 32'h9fc0_0000, USER_BASE 32'h0040_0000, WINDOW_BYTES 32'h400), the state enum, and the buffer-entry struct {pc, data, err}.
REQ-032 The 2-entry FIFO is sub-module imem_fetch_buf; the range check is a function in imem_pkg.

Verification
REQ-033 Reset release, inst_ready=1, memory word i = i -> PCs 9fc0_0000, 9fc0_0004, ... on consecutive cycles, first inst_valid on cycle 2.
REQ-034 inst_ready=0 for 5 cycles during streaming -> no more than 2 reads outstanding or buffered; no instruction lost or duplicated; outputs stable.
REQ-035 redirect_pc=32'h0040_0010 while buffer full -> next delivered inst_pc is 0040_0010 with no stale entries.
REQ-036 redirect_pc=32'h0040_03fc -> delivers 0040_03fc, then fault at 0040_0400 with inst_addr_err=1, then HALT with imem_en=0 until the next redirect.
REQ-037 redirect_pc=32'h9fc0_0002 -> single fault entry, no imem_en pulse.
REQ-038 rst_n asserted mid-stream -> outputs zero immediately; refetch from 9fc0_0000 after release.
